// File: rtl/median_host_ctrl.sv
// median_host_ctrl: host-side loader / launcher / reader for MEDIAN_Top.
// Streams 32-bit words into MemA, starts the core, waits for Done_t, then
// streams the result bytes out of MemO port B.
// Optional Done_t watchdog and ERR state: define MEDIAN_HOST_TIMEOUT_EN.
module median_host_ctrl #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned R_WIDTH = 3,
    parameter int unsigned RD_LAT  = 2
`ifdef MEDIAN_HOST_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYC  = 4096
`endif
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Start,
    output logic                       Busy,
    input  logic                       In_valid,
    output logic                       In_ready,
    input  logic [31:0]                In_data,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic [D_WIDTH-1:0]         Out_data,
    output logic                       Out_last,
    output logic                       Err,
    output logic                       Rst_Core,
    output logic                       Go_t,
    input  logic                       Done_t,
    output logic [31:0]                MA_di32,
    output logic [A_WIDTH-3:0]         MA_Addr6,
    output logic                       MA_enb,
    output logic                       MA_web,
    output logic [A_WIDTH-R_WIDTH-1:0] MO_Addr5b,
    output logic                       MO_enb,
    output logic                       MO_web,
    input  logic [D_WIDTH-1:0]         MO_do8b
);

    localparam int unsigned AW      = A_WIDTH - 2;
    localparam int unsigned OW      = A_WIDTH - R_WIDTH;
    localparam int unsigned WC_W    = A_WIDTH - 1;
    localparam int unsigned RC_W    = OW + 1;
    localparam int unsigned N_WORDS = 1 << AW;
    localparam int unsigned N_RES   = 1 << OW;
    localparam int unsigned LC_W    = $clog2(RD_LAT + 1);

    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(N_WORDS - 1);
    localparam logic [RC_W-1:0] RES_LAST  = RC_W'(N_RES - 1);
    localparam logic [LC_W-1:0] LAT_LAST  = LC_W'(RD_LAT);

`ifdef MEDIAN_HOST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] TO_LAST = WD_W'(TO_CYC - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_WAIT,
        S_READ
`ifdef MEDIAN_HOST_TIMEOUT_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WC_W-1:0]     wcnt;
    logic [RC_W-1:0]     rcnt;
    logic [LC_W-1:0]     lcnt;
    logic                go_d;
    logic                ld_hs;
    logic                rd_hs;
    logic                rd_cap;
    logic                rd_enter;
    logic                core_held;
`ifdef MEDIAN_HOST_TIMEOUT_EN
    logic [WD_W-1:0]     wdog;
`endif

    // Input handshake is qualified by the state alone.
    assign In_ready = (state == S_LOAD);
    assign MO_web   = 1'b0;

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake decode.
    always_comb begin
        state_next = state;
        ld_hs      = 1'b0;
        rd_hs      = 1'b0;
        rd_cap     = 1'b0;
        rd_enter   = 1'b0;
        core_held  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_LOAD;
            end
            S_LOAD: begin
                ld_hs = In_valid;
                if (In_valid && (wcnt == WORD_LAST)) state_next = S_GO;
            end
            S_GO: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A Done_t left over from before the Go_t pulse is ignored.
                if (Done_t && !go_d) begin
                    state_next = S_READ;
                    rd_enter   = 1'b1;
                end
`ifdef MEDIAN_HOST_TIMEOUT_EN
                else if (wdog == TO_LAST) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_READ: begin
                rd_cap = MO_enb && (lcnt == LAT_LAST);
                rd_hs  = Out_valid && Out_ready;
                if (rd_hs && (rcnt == RES_LAST)) state_next = S_IDLE;
            end
`ifdef MEDIAN_HOST_TIMEOUT_EN
            S_ERR: begin
                if (Start) state_next = S_LOAD;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Core is held in reset whenever no job is running on it.
        core_held = (state_next == S_IDLE) || (state_next == S_LOAD);
`ifdef MEDIAN_HOST_TIMEOUT_EN
        core_held = core_held || (state_next == S_ERR);
`endif
    end

    // Status outputs registered from the next state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Busy     <= 1'b0;
            Rst_Core <= 1'b1;
            Go_t     <= 1'b0;
            go_d     <= 1'b0;
        end else begin
            Busy     <= (state_next != S_IDLE);
            Rst_Core <= core_held;
            Go_t     <= (state_next == S_GO);
            go_d     <= (state == S_GO);
        end
    end

`ifdef MEDIAN_HOST_TIMEOUT_EN
    // Watchdog over WAIT and the sticky abort flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wdog <= '0;
            Err  <= 1'b0;
        end else begin
            wdog <= (state == S_WAIT) ? wdog + WD_W'(1) : '0;
            Err  <= (state_next == S_ERR);
        end
    end
`else
    assign Err = 1'b0;
`endif

    // MemA write port: one registered write per accepted input word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wcnt     <= '0;
            MA_enb   <= 1'b0;
            MA_web   <= 1'b0;
            MA_Addr6 <= '0;
            MA_di32  <= '0;
        end else begin
            MA_enb <= ld_hs;
            MA_web <= ld_hs;
            if (ld_hs) begin
                MA_Addr6 <= AW'(wcnt);
                MA_di32  <= In_data;
            end
            if (state != S_LOAD) begin
                wcnt <= '0;
            end else if (ld_hs) begin
                wcnt <= wcnt + WC_W'(1);
            end
        end
    end

    // MemO read sequencing and output byte register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rcnt      <= '0;
            lcnt      <= '0;
            MO_enb    <= 1'b0;
            MO_Addr5b <= '0;
            Out_valid <= 1'b0;
            Out_data  <= '0;
            Out_last  <= 1'b0;
        end else if (rd_enter) begin
            rcnt      <= '0;
            lcnt      <= '0;
            MO_enb    <= 1'b1;
            MO_Addr5b <= '0;
        end else if (rd_cap) begin
            MO_enb    <= 1'b0;
            Out_valid <= 1'b1;
            Out_data  <= MO_do8b;
            Out_last  <= (rcnt == RES_LAST);
        end else if (state == S_READ && MO_enb) begin
            lcnt <= lcnt + LC_W'(1);
        end else if (rd_hs) begin
            Out_valid <= 1'b0;
            Out_last  <= 1'b0;
            rcnt      <= rcnt + RC_W'(1);
            if (rcnt != RES_LAST) begin
                MO_enb    <= 1'b1;
                MO_Addr5b <= OW'(rcnt + RC_W'(1));
                lcnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_median_host_ctrl.sv
// Bench for median_host_ctrl: models MemA, a MEDIAN core and MemO port B,
// and compares the result stream with medians of the words it sent.
module tb_median_host_ctrl;

    localparam int WORDS = 64;
    localparam int NRES  = 32;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic        Busy;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] In_data;
    logic        Out_valid;
    logic        Out_ready;
    logic [7:0]  Out_data;
    logic        Out_last;
    logic        Err;
    logic        Rst_Core;
    logic        Go_t;
    logic        Done_t;
    logic [31:0] MA_di32;
    logic [5:0]  MA_Addr6;
    logic        MA_enb;
    logic        MA_web;
    logic [4:0]  MO_Addr5b;
    logic        MO_enb;
    logic        MO_web;
    logic [7:0]  MO_do8b;

    median_host_ctrl dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Busy      (Busy),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .In_data   (In_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Out_last  (Out_last),
        .Err       (Err),
        .Rst_Core  (Rst_Core),
        .Go_t      (Go_t),
        .Done_t    (Done_t),
        .MA_di32   (MA_di32),
        .MA_Addr6  (MA_Addr6),
        .MA_enb    (MA_enb),
        .MA_web    (MA_web),
        .MO_Addr5b (MO_Addr5b),
        .MO_enb    (MO_enb),
        .MO_web    (MO_web),
        .MO_do8b   (MO_do8b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vecs = 0;
    int errs = 0;

    logic [31:0] words   [WORDS];
    logic [7:0]  exp_res [NRES];

    // Lower median of the eight bytes held in two little-endian words.
    function automatic logic [7:0] med8(input logic [31:0] lo, input logic [31:0] hi);
        logic [7:0] b [8];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) begin
            b[i]     = lo[8*i +: 8];
            b[i + 4] = hi[8*i +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (b[j] > b[j + 1]) begin
                    t = b[j]; b[j] = b[j + 1]; b[j + 1] = t;
                end
            end
        end
        return b[3];
    endfunction

    // MemA model with a log of every write address.
    logic [31:0] mema [WORDS];
    logic [5:0]  wr_log [$];
    always @(posedge Clk) begin
        if (MA_enb && MA_web) begin
            mema[MA_Addr6] <= MA_di32;
            wr_log.push_back(MA_Addr6);
        end
    end

    // Core model: after Go_t, compute medians of MemA into MemO, then raise Done_t.
    logic [7:0] memo [NRES];
    logic       done;
    logic       run;
    int         dly;
    int         go_cnt = 0;
    int         ir_cnt = 0;
    assign Done_t = done;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            done <= 1'b0;
            run  <= 1'b0;
            dly  <= 0;
        end else if (Rst_Core) begin
            done <= 1'b0;
            run  <= 1'b0;
        end else if (Go_t) begin
            run <= 1'b1;
            dly <= 3 + int'($urandom_range(0, 6));
        end else if (run) begin
            if (dly == 0) begin
                for (int i = 0; i < NRES; i++) memo[i] <= med8(mema[2*i], mema[2*i + 1]);
                done <= 1'b1;
                run  <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end
    end

    always @(posedge Clk) begin
        if (Go_t) go_cnt <= go_cnt + 1;
        if (In_ready) ir_cnt <= ir_cnt + 1;
    end

    // MemO port B: two-cycle read latency.
    logic [7:0] d1;
    logic [7:0] d2;
    assign MO_do8b = d2;
    always @(posedge Clk) begin
        if (MO_enb) d1 <= memo[MO_Addr5b];
        d2 <= d1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < WORDS; k++)
            words[k] = (mode == 0) ? 32'h03020100 + 32'(k) * 32'h04040404 : $urandom;
        for (int i = 0; i < NRES; i++)
            exp_res[i] = (mode == 0) ? 8'(8*i + 3) : med8(words[2*i], words[2*i + 1]);
    endtask

    // mode 0: In_valid always high, 1: alternating, 2: random.
    task automatic do_load(input int mode, input int stop_at);
        int k;
        int cyc;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < stop_at && cyc < 2000) begin
            case (mode)
                0:       In_valid = 1'b1;
                1:       In_valid = (cyc % 2 == 0);
                default: In_valid = 1'($urandom_range(0, 1));
            endcase
            In_data = words[k];
            if (In_valid && In_ready) k++;
            @(posedge Clk); #1;
            cyc++;
        end
        In_valid = 1'b0;
        chk("load_count", 64'(k), 64'(stop_at));
    endtask

    task automatic do_read(input bit rnd, input bit stall);
        int idx;
        int cyc;
        int hold;
        idx = 0;
        cyc = 0;
        hold = 0;
        while (idx < NRES && cyc < 4000) begin
            Start = (cyc < 3);
            Out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && idx == 7 && Out_valid && hold < 5) begin
                Out_ready = 1'b0;
                hold++;
                chk("stall_data", 64'(Out_data), 64'(exp_res[7]));
                chk("stall_mo_enb", 64'(MO_enb), 64'd0);
                chk("stall_mo_web", 64'(MO_web), 64'd0);
            end
            if (Out_valid && Out_ready) begin
                chk("rd_data", 64'(Out_data), 64'(exp_res[idx]));
                chk("rd_last", 64'(Out_last), 64'(idx == NRES - 1));
                idx++;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0;
        Out_ready = 1'b0;
        chk("rd_count", 64'(idx), 64'(NRES));
        chk("stall_len", 64'(hold), stall ? 64'd5 : 64'd0);
        chk("busy_drop", 64'(Busy), 64'd0);
        chk("rst_core_idle", 64'(Rst_Core), 64'd1);
        chk("out_valid_idle", 64'(Out_valid), 64'd0);
    endtask

    task automatic run_job(input int lmode, input bit rnd, input bit stall);
        int wb;
        int gb;
        int ib;
        fill(lmode);
        wb = wr_log.size();
        gb = go_cnt;
        ib = ir_cnt;
        do_load(lmode, WORDS);
        chk("go_cycle_go_t", 64'(Go_t), 64'd1);
        chk("go_cycle_in_ready", 64'(In_ready), 64'd0);
        chk("go_cycle_rst_core", 64'(Rst_Core), 64'd0);
        do_read(rnd, stall);
        chk("go_pulses", 64'(go_cnt - gb), 64'd1);
        if (lmode == 0) chk("in_ready_cycles", 64'(ir_cnt - ib), 64'(WORDS));
        chk("write_count", 64'(wr_log.size() - wb), 64'(WORDS));
        for (int j = 0; j < WORDS; j++) begin
            if (wb + j < wr_log.size()) chk("write_addr", 64'(wr_log[wb + j]), 64'(j));
            chk("mema_word", 64'(mema[j]), 64'(words[j]));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rst_core", 64'(Rst_Core), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_in_ready", 64'(In_ready), 64'd0);
        chk("rst_out_valid", 64'(Out_valid), 64'd0);
        chk("rst_out_last", 64'(Out_last), 64'd0);
        chk("rst_out_data", 64'(Out_data), 64'd0);
        chk("rst_go_t", 64'(Go_t), 64'd0);
        chk("rst_err", 64'(Err), 64'd0);
        chk("rst_ma_enb", 64'(MA_enb), 64'd0);
        chk("rst_ma_web", 64'(MA_web), 64'd0);
        chk("rst_ma_addr", 64'(MA_Addr6), 64'd0);
        chk("rst_ma_data", 64'(MA_di32), 64'd0);
        chk("rst_mo_enb", 64'(MO_enb), 64'd0);
        chk("rst_mo_addr", 64'(MO_Addr5b), 64'd0);
    endtask

    initial begin
        Rst_n     = 1'b0;
        Start     = 1'b0;
        In_valid  = 1'b0;
        In_data   = '0;
        Out_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge Clk);
        #1;
        chk_reset_outputs();
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("idle_busy", 64'(Busy), 64'd0);

        // Ramp pattern, full-rate input and output.
        run_job(0, 1'b0, 1'b0);
        @(posedge Clk); #1;

        // Alternating input valid, random sink, stall on byte 7.
        run_job(1, 1'b1, 1'b1);
        @(posedge Clk); #1;

        // Reset asserted mid-load after ten words.
        fill(2);
        do_load(0, 10);
        chk("midload_busy", 64'(Busy), 64'd1);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        chk_reset_outputs();
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Fresh job after the abort, random valid and ready.
        run_job(2, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
